// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types and default constants for the MIPS CPU sequencer
// Contents:
//   state_t              sequencer state encoding
//   DEFAULT_RESET_VECTOR PC loaded by reset
//   DEFAULT_HALT_ADDR    committed jump target that stops the CPU
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        FETCH      = 3'd0,
        EXEC       = 3'd1,
        MEM        = 3'd2,
        WRITE_BACK = 3'd3,
        HALTED     = 3'd4
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/mips_cpu_delay_slot.sv
// rtl/mips_cpu_delay_slot.sv - branch delay slot tracker with first-target-wins rule
// Ports:
//   clk, rst, clk_enable  clock, sync active-high reset, advance enable
//   record, target        taken branch seen in EXEC and its target
//   consume               current instruction is in WRITE_BACK
//   redirect              this WRITE_BACK commits the delay slot: load target_q into pc
//   halt_req              redirect to the halt address
//   target_q              latched branch target
module mips_cpu_delay_slot #(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    input  logic              record,
    input  logic [ADDR_W-1:0] target,
    input  logic              consume,
    output logic              redirect,
    output logic              halt_req,
    output logic [ADDR_W-1:0] target_q
);

    logic pending;
    // Set while the branch instruction itself is still in flight; its own
    // WRITE_BACK must step to the delay slot rather than redirect.
    logic just_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            just_set <= 1'b0;
            target_q <= '0;
        end else if (clk_enable) begin
            // A branch in the delay slot finds pending already set and is dropped.
            if (record && !pending) begin
                pending  <= 1'b1;
                just_set <= 1'b1;
                target_q <= target;
            end
            if (consume) begin
                if (just_set) begin
                    just_set <= 1'b0;
                end else if (pending) begin
                    pending <= 1'b0;
                end
            end
        end
    end

    assign redirect = pending && !just_set;
    assign halt_req = redirect && (target_q == HALT_ADDR);

endmodule

// File: rtl/mips_cpu_seq_ctrl.sv
// rtl/mips_cpu_seq_ctrl.sv - multicycle FETCH/EXEC/MEM/WRITE_BACK sequencer owning PC and IR
// Ports:
//   clk, rst, clk_enable                 clock, sync active-high reset, advance enable
//   active, state, error                 status: not halted, current state, sticky decode error
//   pc, instr_address, instr_read,
//   instr_waitrequest, instr_readdata    instruction fetch port
//   ir                                   latched instruction to the decoder
//   dec_*                                decoder results, sampled in EXEC
//   data_read, data_write,
//   data_waitrequest                     data access strobes and handshake
//   reg_write_en                         register file write enable
module mips_cpu_seq_ctrl
    import mips_cpu_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(DEFAULT_HALT_ADDR),
    parameter int unsigned       PC_STEP      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    output logic              active,
    output state_t            state,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] instr_address,
    output logic              instr_read,
    input  logic              instr_waitrequest,
    input  logic [31:0]       instr_readdata,
    output logic [31:0]       ir,
    input  logic              dec_mem_read,
    input  logic              dec_mem_write,
    input  logic              dec_reg_write,
    input  logic              dec_ctrl_xfer,
    input  logic [ADDR_W-1:0] dec_target,
    output logic              data_read,
    output logic              data_write,
    input  logic              data_waitrequest,
    output logic              reg_write_en,
    output logic              error
);

    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              reg_wr_q;
    logic              redirect;
    logic              halt_req;
    logic [ADDR_W-1:0] target_q;
    logic              both_mem;

    assign both_mem = dec_mem_read && dec_mem_write;

    mips_cpu_delay_slot #(
        .ADDR_W    (ADDR_W),
        .HALT_ADDR (HALT_ADDR)
    ) u_delay_slot (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .record     ((state == EXEC) && dec_ctrl_xfer && !both_mem),
        .target     (dec_target),
        .consume    (state == WRITE_BACK),
        .redirect   (redirect),
        .halt_req   (halt_req),
        .target_q   (target_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_VECTOR;
            ir       <= '0;
            error    <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            reg_wr_q <= 1'b0;
        end else if (clk_enable) begin
            case (state)
                FETCH: begin
                    if (!instr_waitrequest) begin
                        ir    <= instr_readdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Decode is latched so MEM/WRITE_BACK do not depend on
                    // the decoder holding its outputs.
                    mem_rd_q <= dec_mem_read;
                    mem_wr_q <= dec_mem_write;
                    reg_wr_q <= dec_reg_write;
                    if (both_mem) begin
                        error <= 1'b1;
                        state <= HALTED;
                    end else if (dec_mem_read || dec_mem_write) begin
                        state <= MEM;
                    end else begin
                        state <= WRITE_BACK;
                    end
                end
                MEM: begin
                    if (!data_waitrequest) begin
                        state <= WRITE_BACK;
                    end
                end
                WRITE_BACK: begin
                    if (redirect) begin
                        pc    <= target_q;
                        state <= halt_req ? HALTED : FETCH;
                    end else begin
                        pc    <= pc + ADDR_W'(PC_STEP);
                        state <= FETCH;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

    assign active        = (state != HALTED);
    assign instr_address = pc;
    assign instr_read    = (state == FETCH);
    assign data_read     = (state == MEM) && mem_rd_q;
    assign data_write    = (state == MEM) && mem_wr_q && !mem_rd_q;
    assign reg_write_en  = (state == WRITE_BACK) && reg_wr_q;

endmodule

// File: tb/tb_mips_cpu_seq_ctrl.sv
// tb/tb_mips_cpu_seq_ctrl.sv - directed self-checking bench for mips_cpu_seq_ctrl
module tb_mips_cpu_seq_ctrl;
    import mips_cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        clk_enable;
    logic        active;
    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;
    logic [31:0] ir;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_reg_write;
    logic        dec_ctrl_xfer;
    logic [31:0] dec_target;
    logic        data_read;
    logic        data_write;
    logic        data_waitrequest;
    logic        reg_write_en;
    logic        error;

    int vectors;
    int miscompares;

    mips_cpu_seq_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .clk_enable        (clk_enable),
        .active            (active),
        .state             (state),
        .pc                (pc),
        .instr_address     (instr_address),
        .instr_read        (instr_read),
        .instr_waitrequest (instr_waitrequest),
        .instr_readdata    (instr_readdata),
        .ir                (ir),
        .dec_mem_read      (dec_mem_read),
        .dec_mem_write     (dec_mem_write),
        .dec_reg_write     (dec_reg_write),
        .dec_ctrl_xfer     (dec_ctrl_xfer),
        .dec_target        (dec_target),
        .data_read         (data_read),
        .data_write        (data_write),
        .data_waitrequest  (data_waitrequest),
        .reg_write_en      (reg_write_en),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        rst               = 1'b1;
        clk_enable        = 1'b1;
        instr_waitrequest = 1'b0;
        instr_readdata    = 32'h0;
        dec_mem_read      = 1'b0;
        dec_mem_write     = 1'b0;
        dec_reg_write     = 1'b0;
        dec_ctrl_xfer     = 1'b0;
        dec_target        = 32'h0;
        data_waitrequest  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", pc, 32'hBFC0_0000);
        chk("rst_ir", ir, 32'h0);
        chk("rst_active", 32'(active), 32'd1);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_instr_read", 32'(instr_read), 32'd1);
        chk("rst_reg_write_en", 32'(reg_write_en), 32'd0);
        rst = 1'b0;

        // Three ALU instructions, zero-wait memory
        dec_reg_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_readdata = 32'h0000_1000 + i;
            chk("alu_fetch_state", 32'(state), 32'd0);
            chk("alu_fetch_pc", pc, 32'hBFC0_0000 + 32'(4 * i));
            chk("alu_instr_address", instr_address, 32'hBFC0_0000 + 32'(4 * i));
            tick();
            chk("alu_exec_state", 32'(state), 32'd1);
            chk("alu_ir", ir, 32'h0000_1000 + i);
            tick();
            chk("alu_wb_state", 32'(state), 32'd3);
            chk("alu_reg_write_en", 32'(reg_write_en), 32'd1);
            tick();
            chk("alu_reg_write_drop", 32'(reg_write_en), 32'd0);
        end

        // Fetch stalled for 3 cycles
        chk("stall_pc", pc, 32'hBFC0_000C);
        dec_reg_write     = 1'b0;
        instr_waitrequest = 1'b1;
        instr_readdata    = 32'h2222_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_state", 32'(state), 32'd0);
            chk("stall_instr_read", 32'(instr_read), 32'd1);
            chk("stall_ir_held", ir, 32'h0000_1002);
        end
        instr_waitrequest = 1'b0;
        tick();
        chk("stall_exec", 32'(state), 32'd1);
        chk("stall_ir", ir, 32'h2222_0000);
        tick();
        chk("stall_wb_no_write", 32'(reg_write_en), 32'd0);
        tick();
        chk("jump_fetch_pc", pc, 32'hBFC0_0010);

        // Jump at BFC00010 to BFC00100
        dec_ctrl_xfer  = 1'b1;
        dec_target     = 32'hBFC0_0100;
        instr_readdata = 32'h0BF0_0040;
        tick();
        tick();
        dec_ctrl_xfer = 1'b0;
        chk("jump_wb_state", 32'(state), 32'd3);
        tick();
        chk("delay_slot_pc", pc, 32'hBFC0_0014);

        // Delay slot is a load with 2 wait cycles
        instr_readdata   = 32'h8C01_0000;
        dec_mem_read     = 1'b1;
        dec_reg_write    = 1'b1;
        data_waitrequest = 1'b1;
        tick();
        chk("load_exec", 32'(state), 32'd1);
        tick();
        chk("load_mem1_read", 32'(data_read), 32'd1);
        chk("load_mem1_write", 32'(data_write), 32'd0);
        tick();
        chk("load_mem2_read", 32'(data_read), 32'd1);
        tick();
        chk("load_mem3_read", 32'(data_read), 32'd1);
        data_waitrequest = 1'b0;
        tick();
        chk("load_wb_state", 32'(state), 32'd3);
        chk("load_wb_reg_write", 32'(reg_write_en), 32'd1);
        chk("load_wb_read_drop", 32'(data_read), 32'd0);
        dec_mem_read  = 1'b0;
        dec_reg_write = 1'b0;
        tick();
        chk("jump_target_state", 32'(state), 32'd0);
        chk("jump_target_pc", pc, 32'hBFC0_0100);

        // Store frozen mid-MEM by clk_enable
        dec_mem_write    = 1'b1;
        data_waitrequest = 1'b1;
        tick();
        tick();
        chk("store_mem_write", 32'(data_write), 32'd1);
        clk_enable       = 1'b0;
        data_waitrequest = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("freeze_state", 32'(state), 32'd2);
            chk("freeze_pc", pc, 32'hBFC0_0100);
            chk("freeze_data_write", 32'(data_write), 32'd1);
        end
        clk_enable = 1'b1;
        tick();
        chk("store_wb", 32'(state), 32'd3);
        dec_mem_write = 1'b0;
        tick();
        chk("halt_jump_pc", pc, 32'hBFC0_0104);

        // Jump to 0 with a second branch in the delay slot, which must be ignored
        dec_ctrl_xfer = 1'b1;
        dec_target    = 32'h0000_0000;
        tick();
        tick();
        dec_target = 32'hBFC0_0500;
        tick();
        chk("halt_delay_pc", pc, 32'hBFC0_0108);
        tick();
        tick();
        dec_ctrl_xfer = 1'b0;
        chk("halt_delay_wb", 32'(state), 32'd3);
        tick();
        chk("halted_state", 32'(state), 32'd4);
        chk("halted_active", 32'(active), 32'd0);
        chk("halted_pc", pc, 32'h0000_0000);
        for (int i = 0; i < 20; i++) begin
            instr_waitrequest = i[0];
            tick();
            chk("halted_quiet", {28'd0, instr_read, data_read, data_write, reg_write_en}, 32'd0);
        end
        instr_waitrequest = 1'b0;
        rst = 1'b1;
        tick();
        chk("rerst_pc", pc, 32'hBFC0_0000);
        chk("rerst_active", 32'(active), 32'd1);
        chk("rerst_state", 32'(state), 32'd0);
        rst = 1'b0;

        // Reset during a stalled load
        dec_mem_read     = 1'b1;
        dec_reg_write    = 1'b1;
        data_waitrequest = 1'b1;
        tick();
        tick();
        chk("midmem_read", 32'(data_read), 32'd1);
        rst = 1'b1;
        tick();
        chk("midmem_read_drop", 32'(data_read), 32'd0);
        chk("midmem_state", 32'(state), 32'd0);
        chk("midmem_no_write", 32'(reg_write_en), 32'd0);
        rst = 1'b0;

        // Both memory decodes high in EXEC
        dec_mem_write = 1'b1;
        tick();
        chk("err_exec_flag", 32'(error), 32'd0);
        tick();
        chk("err_state", 32'(state), 32'd4);
        chk("err_flag", 32'(error), 32'd1);
        chk("err_strobes", {30'd0, data_read, data_write}, 32'd0);
        chk("err_active", 32'(active), 32'd0);
        rst = 1'b1;
        tick();
        chk("err_cleared", 32'(error), 32'd0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_cpu_seq_ctrl.md
Name: mips_cpu_seq_ctrl

Overview:
Parametrised multicycle sequencer for the MIPS CPU. It owns the PC, the instruction register and the FETCH/EXEC/MEM/WRITE_BACK/HALTED state machine. Fetch and data accesses use waitrequest handshakes, so instruction and data memories may have variable latency. It implements the MIPS branch delay slot and halts the CPU on a jump to HALT_ADDR. It sits between the instruction/data memory ports and the decoder, register file and ALU datapath.

Parameters:
ADDR_W, 32, width of PC and memory addresses
RESET_VECTOR, 32'hBFC00000, PC value after reset
HALT_ADDR, 32'h00000000, committed branch/jump target that halts the CPU
PC_STEP, 4, PC increment per committed instruction

Ports:
clk  in  1  clock
rst  in  1  reset
clk_enable  in  1  global advance enable; low freezes all state
active  out  1  high while not HALTED
state  out  3  current state encoding (state_t)
pc  out  ADDR_W  PC of the instruction in flight
instr_address  out  ADDR_W  equals pc
instr_read  out  1  fetch strobe
instr_waitrequest  in  1  high = fetch not yet complete
instr_readdata  in  32  fetched word
ir  out  32  latched instruction, fed to decoder
dec_mem_read  in  1  decoded load (sampled in EXEC)
dec_mem_write  in  1  decoded store (sampled in EXEC)
dec_reg_write  in  1  decoded register writeback
dec_ctrl_xfer  in  1  taken branch or jump (sampled in EXEC)
dec_target  in  ADDR_W  branch/jump target (sampled in EXEC)
data_read  out  1  load strobe
data_write  out  1  store strobe
data_waitrequest  in  1  high = data access not yet complete
reg_write_en  out  1  register file write enable
error  out  1  sticky protocol error flag

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. Reset has priority over clk_enable.
- Reset values: state=FETCH, pc=RESET_VECTOR, ir=0, active=1, error=0, delay-slot pending=0.
- Strobes and reg_write_en are combinational from state, so instr_read=1 immediately after reset.
- clk_enable=0: no register changes. Strobes hold their current values.
- FETCH:
  - instr_read=1.
  - While instr_waitrequest=1, stay in FETCH.
  - When instr_waitrequest=0: ir<=instr_readdata, go to EXEC. Minimum latency is 1 cycle.
- EXEC: exactly one cycle.
  - dec_mem_read and dec_mem_write both high: error<=1, go to HALTED.
  - Otherwise, either high: go to MEM. Neither high: go to WRITE_BACK.
  - If dec_ctrl_xfer=1 and pending=0: pending<=1, target_q<=dec_target.
  - If dec_ctrl_xfer=1 and pending=1 (branch in delay slot): ignore it; the first target wins.
- MEM:
  - data_read or data_write is asserted per the latched EXEC decode.
  - Hold the strobe until data_waitrequest=0, then go to WRITE_BACK.
  - Only one strobe is ever high.
- WRITE_BACK: one cycle.
  - reg_write_en = latched dec_reg_write.
  - PC update:
    - Branch just recorded in this instruction's EXEC (the branch itself): pc<=pc+PC_STEP so the delay slot executes.
    - Else if pending=1: pending<=0, pc<=target_q. If target_q==HALT_ADDR, go to HALTED; otherwise go to FETCH.
    - Else: pc<=pc+PC_STEP, go to FETCH.
  - pc+PC_STEP wraps modulo 2^ADDR_W with no flag.
- HALTED:
  - active=0; all strobes and reg_write_en are 0.
  - Stays in HALTED until rst.
- Reset mid-fetch or mid-memory access: strobes drop on the cycle after the rst edge. The in-flight instruction is discarded and has no register write.
- Cycle counts (memory with zero wait): ALU instruction = 3 cycles (FETCH, EXEC, WB); load/store = 4 cycles.

Decomposition:
- Package mips_cpu_pkg holds:
  - typedef enum logic[2:0] state_t: FETCH=0, EXEC=1, MEM=2, WRITE_BACK=3, HALTED=4.
  - Default RESET_VECTOR and HALT_ADDR constants.
- One sub-module, mips_cpu_delay_slot: holds the pending/target_q register and the first-wins rule, and outputs redirect and halt_req.
- The sequencer instantiates mips_cpu_delay_slot and owns the FSM and PC.

Test Plan:
- Reset, zero-wait memory, 3 ALU instructions -> pc steps BFC00000, BFC00004, BFC00008; WRITE_BACK at cycles 3, 6, 9; reg_write_en high 1 cycle each.
- Fetch with instr_waitrequest high for 3 cycles -> instr_read held 4 cycles; ir updates only on the release cycle; EXEC follows the next cycle.
- Load with data_waitrequest high for 2 cycles -> data_read high 3 cycles; then WRITE_BACK with reg_write_en=1; total 6 cycles.
- Jump at BFC00010 to BFC00100 -> delay slot at BFC00014 fetches and commits; next fetch is at BFC00100.
- Jump to 0x00000000 -> delay slot commits, state=HALTED, active=0; no further strobes for 20 cycles; then rst -> pc=BFC00000, active=1.
- EXEC with both mem decodes high -> error=1, HALTED. clk_enable low for 5 cycles mid-MEM -> state, pc and strobes frozen.
